// File: rtl/cascade_counter_bank_if.sv
// Control and status bundle for cascade_counter_bank: step/load controls in,
// digit values and chain flags out.
interface cascade_counter_bank_if #(
  parameter int N_DIGITS = 4
);
  logic                  ce;
  logic                  up;
  logic                  sat;
  logic                  load;
  logic [4*N_DIGITS-1:0] load_val;
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   tc_vec;
  logic                  tc;
  logic                  ceo;
  logic                  tick;

  modport master (
    output ce, up, sat, load, load_val,
    input  digits, tc_vec, tc, ceo, tick
  );

  modport slave (
    input  ce, up, sat, load, load_val,
    output digits, tc_vec, tc, ceo, tick
  );
endinterface

// File: rtl/cascade_counter_bank.sv
// Chain of radix-RADIX digit counters on one clock, stepped by a prescaler tick,
// with up/down, clamped parallel load and wrap/saturate at the chain ends.
module cascade_counter_bank #(
  parameter int N_DIGITS  = 4,
  parameter int RADIX     = 10,
  parameter int DIV_WIDTH = 20
) (
  input  logic                   sys_clk,
  input  logic                   clr,
  cascade_counter_bank_if.slave  bus
);

  localparam logic [3:0] DIGIT_MAX = 4'(RADIX - 1);

  logic [DIV_WIDTH-1:0]       pre_q, pre_d;
  logic [N_DIGITS-1:0][3:0]   digits_q, digits_d;
  logic [N_DIGITS-1:0]        tc_vec;
  logic                       tick;
  logic                       tc;
  logic                       step;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    tick  = &pre_q;
    pre_d = pre_q + DIV_WIDTH'(1);
    for (int i = 0; i < N_DIGITS; i++) begin
      tc_vec[i] = bus.up ? (digits_q[i] == DIGIT_MAX) : (digits_q[i] == 4'd0);
    end
    tc   = &tc_vec;
    step = bus.ce & tick & ~bus.load & ~clr;
  end

  always_comb begin
    logic carry;
    digits_d = digits_q;
    // A saturated chain end blocks the carry into digit 0, freezing the whole chain.
    carry    = step & ~(bus.sat & tc);
    if (bus.load) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        digits_d[i] = (bus.load_val[4*i +: 4] > DIGIT_MAX) ? DIGIT_MAX : bus.load_val[4*i +: 4];
      end
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (carry) begin
          if (bus.up) begin
            digits_d[i] = (digits_q[i] == DIGIT_MAX) ? 4'd0 : digits_q[i] + 4'd1;
          end else begin
            digits_d[i] = (digits_q[i] == 4'd0) ? DIGIT_MAX : digits_q[i] - 4'd1;
          end
        end
        carry = carry & tc_vec[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      pre_q    <= '0;
      digits_q <= '0;
    end else begin
      pre_q    <= pre_d;
      digits_q <= digits_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.tc_vec = tc_vec;
  assign bus.tc     = tc;
  assign bus.ceo    = step & tc & ~bus.sat;
  assign bus.tick   = tick;

endmodule

// File: tb/tb_cascade_counter_bank.sv
// Drives a decimal and a hex bank with identical stimulus and checks both
// against an integer-valued model every cycle, plus literal expectations.
module tb_cascade_counter_bank;

  localparam int ND = 4;
  localparam int DW = 2;
  localparam int TICK_AT = (1 << DW) - 1;

  logic        sys_clk = 1'b0;
  logic        clr, ce, up, sat, load;
  logic [15:0] load_val;
  logic        chk_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  cascade_counter_bank_if #(.N_DIGITS(ND)) bus10 ();
  cascade_counter_bank_if #(.N_DIGITS(ND)) bus16 ();

  assign bus10.ce = ce;  assign bus10.up = up;  assign bus10.sat = sat;
  assign bus10.load = load;  assign bus10.load_val = load_val;
  assign bus16.ce = ce;  assign bus16.up = up;  assign bus16.sat = sat;
  assign bus16.load = load;  assign bus16.load_val = load_val;

  cascade_counter_bank #(.N_DIGITS(ND), .RADIX(10), .DIV_WIDTH(DW)) dut10 (
    .sys_clk(sys_clk), .clr(clr), .bus(bus10.slave));
  cascade_counter_bank #(.N_DIGITS(ND), .RADIX(16), .DIV_WIDTH(DW)) dut16 (
    .sys_clk(sys_clk), .clr(clr), .bus(bus16.slave));

  always #5 sys_clk = ~sys_clk;

  logic [15:0] dig [2];
  logic [3:0]  tcv [2];
  logic        tcs [2], ceos [2], ticks [2];
  assign dig[0] = bus10.digits;  assign dig[1] = bus16.digits;
  assign tcv[0] = bus10.tc_vec;  assign tcv[1] = bus16.tc_vec;
  assign tcs[0] = bus10.tc;      assign tcs[1] = bus16.tc;
  assign ceos[0] = bus10.ceo;    assign ceos[1] = bus16.ceo;
  assign ticks[0] = bus10.tick;  assign ticks[1] = bus16.tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: chain value held as a plain integer ----------------
  int m_cnt [2] = '{0, 0};
  int m_pre = 0;

  function automatic int rdx(input int k);
    return (k == 0) ? 10 : 16;
  endfunction

  function automatic logic [15:0] pack(input int v, input int r);
    logic [15:0] o;
    for (int i = 0; i < ND; i++) begin
      o[4*i +: 4] = 4'(v % r);
      v = v / r;
    end
    return o;
  endfunction

  function automatic int clamp_val(input logic [15:0] lv, input int r);
    int v, f;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      f = int'(lv[4*i +: 4]);
      if (f >= r) f = r - 1;
      v = v * r + f;
    end
    return v;
  endfunction

  function automatic int next_cnt(input int c, input int r);
    int mx;
    mx = r ** ND - 1;
    if (load) return clamp_val(load_val, r);
    if (!(ce && m_pre == TICK_AT)) return c;
    if (up) return (c == mx) ? (sat ? c : 0) : c + 1;
    return (c == 0) ? (sat ? c : mx) : c - 1;
  endfunction

  always @(posedge sys_clk) begin
    if (clr) begin
      m_pre <= 0;
      for (int k = 0; k < 2; k++) m_cnt[k] <= 0;
    end else begin
      m_pre <= (m_pre + 1) % (1 << DW);
      for (int k = 0; k < 2; k++) m_cnt[k] <= next_cnt(m_cnt[k], rdx(k));
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int r, mx, d, w;
        logic [3:0] etv;
        logic etc, etick;
        r  = rdx(k);
        mx = r ** ND - 1;
        w  = m_cnt[k];
        for (int i = 0; i < ND; i++) begin
          d = w % r;
          w = w / r;
          etv[i] = up ? (d == r - 1) : (d == 0);
        end
        etc   = up ? (m_cnt[k] == mx) : (m_cnt[k] == 0);
        etick = (m_pre == TICK_AT);
        check($sformatf("digits_r%0d", r), 32'(dig[k]), 32'(pack(m_cnt[k], r)));
        check($sformatf("tc_vec_r%0d", r), 32'(tcv[k]), 32'(etv));
        check($sformatf("tc_r%0d", r), 32'(tcs[k]), 32'(etc));
        check($sformatf("tick_r%0d", r), 32'(ticks[k]), 32'(etick));
        check($sformatf("ceo_r%0d", r), 32'(ceos[k]),
              32'(ce && etick && !load && !clr && etc && !sat));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns at the negedge of the next tick cycle; n = posedges waited.
  task automatic wait_tick(output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
      seen = bus10.tick;
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic next_edge();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_ticks(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      wait_tick(n);
      next_edge();
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    next_edge();
    load = 1'b0;
  endtask

  initial begin
    int n;
    clr = 1'b1; ce = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    next_edge();
    chk_en = 1'b1;
    next_edge();
    check("reset_digits10", 32'(bus10.digits), 32'h0000);
    check("reset_tick", 32'(bus10.tick), 32'd0);
    clr = 1'b0;
    ce  = 1'b1;

    // first tick three cycles after release, then count 0001..0010
    wait_tick(n);
    check("first_tick_delay", 32'(n), 32'd3);
    next_edge();
    check("count_first", 32'(bus10.digits), 32'h0001);
    wait_tick(n);
    check("tick_period", 32'(n), 32'd3);
    next_edge();
    run_ticks(8);
    check("count_ten_r10", 32'(bus10.digits), 32'h0010);
    check("count_ten_r16", 32'(bus16.digits), 32'h000A);

    // wrap up
    do_load(16'h9999);
    check("wrap_up_tc", 32'(bus10.tc), 32'd1);
    wait_tick(n);
    check("wrap_up_ceo", 32'(bus10.ceo), 32'd1);
    next_edge();
    check("wrap_up_digits", 32'(bus10.digits), 32'h0000);
    check("wrap_up_hex", 32'(bus16.digits), 32'h999A);

    // wrap down
    up = 1'b0;
    do_load(16'h0000);
    check("wrap_dn_tc", 32'(bus10.tc), 32'd1);
    wait_tick(n);
    check("wrap_dn_ceo", 32'(bus10.ceo), 32'd1);
    next_edge();
    check("wrap_dn_digits", 32'(bus10.digits), 32'h9999);
    check("wrap_dn_hex", 32'(bus16.digits), 32'hFFFF);
    run_ticks(1);
    check("wrap_dn_next", 32'(bus10.digits), 32'h9998);

    // saturate up then down
    sat = 1'b1;
    up  = 1'b1;
    do_load(16'h9998);
    run_ticks(1);
    check("sat_up_reach", 32'(bus10.digits), 32'h9999);
    wait_tick(n);
    check("sat_up_ceo", 32'(bus10.ceo), 32'd0);
    next_edge();
    run_ticks(1);
    check("sat_up_hold", 32'(bus10.digits), 32'h9999);
    up = 1'b0;
    do_load(16'h0001);
    run_ticks(2);
    check("sat_dn_hold", 32'(bus10.digits), 32'h0000);
    check("sat_dn_hold_hex", 32'(bus16.digits), 32'h0000);

    // load on a tick with tc=1, wrap mode: load wins, no ceo
    wait_tick(n);
    #1;
    sat = 1'b0;
    load = 1'b1;
    load_val = 16'hF3A7;
    #1;
    check("load_tick_ceo10", 32'(bus10.ceo), 32'd0);
    check("load_tick_ceo16", 32'(bus16.ceo), 32'd0);
    next_edge();
    load = 1'b0;
    check("load_clamp_r10", 32'(bus10.digits), 32'h9397);
    check("load_clamp_r16", 32'(bus16.digits), 32'hF3A7);

    // hex count to 00FF, then clear on a tick
    up = 1'b1;
    do_load(16'h00F0);
    check("load_clamp_00F0", 32'(bus10.digits), 32'h0090);
    run_ticks(15);
    check("hex_00FF", 32'(bus16.digits), 32'h00FF);
    check("dec_0105", 32'(bus10.digits), 32'h0105);
    wait_tick(n);
    #1;
    clr = 1'b1;
    #1;
    check("clr_tick_ceo", 32'(bus16.ceo), 32'd0);
    next_edge();
    clr = 1'b0;
    check("clr_digits16", 32'(bus16.digits), 32'h0000);
    check("clr_tick_low", 32'(bus16.tick), 32'd0);
    wait_tick(n);
    check("tick_after_clr", 32'(n), 32'd3);
    next_edge();
    check("step_after_clr", 32'(bus16.digits), 32'h0001);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
